// File: rtl/phy_pkg.sv
// phy_pkg: constants and lane-index type shared by phy_tx and phy_rx.
// Revision 1.0
`default_nettype none

package phy_pkg;

  localparam logic [7:0]  COM_BYTE_DEFAULT = 8'hBC;
  localparam int unsigned BITS_PER_FRAME   = 8;

  typedef enum logic {
    LANE_0 = 1'b0,
    LANE_1 = 1'b1
  } lane_idx_e;

  function automatic lane_idx_e next_lane(input lane_idx_e lane);
    return (lane == LANE_0) ? LANE_1 : LANE_0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: 8-bit MSB-first load/shift register for one lane.
// Revision 1.0
`default_nettype none

module phy_tx_serializer (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       serial_o
);

  logic [7:0] shift_q;
  logic [7:0] shift_d;

  always_comb begin
    shift_d = {shift_q[6:0], 1'b0};
    if (load) begin
      shift_d = load_data;
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      shift_q <= 8'h00;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign serial_o = shift_q[7];

endmodule

`default_nettype wire

// File: rtl/phy_tx.sv
// phy_tx: two-source, two-lane striping transmitter serialized at 8f from a single clock.
// Revision 1.0. Optional macro PHY_TX_PREAMBLE_EN adds a COM-only preamble after reset.
`default_nettype none

module phy_tx
  import phy_pkg::*;
#(
  parameter logic [7:0]  COM_BYTE        = COM_BYTE_DEFAULT,
  parameter int unsigned PREAMBLE_FRAMES = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  output logic       frame_sync,
  output logic       out_0,
  output logic       out_1
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_FRAME - 1);

  logic [2:0] bit_cnt_q;
  lane_idx_e  lane_ptr_q;
  lane_idx_e  lane_ptr_d;
  logic [7:0] smp_data_0_q;
  logic [7:0] smp_data_1_q;
  logic [1:0] smp_valid_q;
  logic [7:0] load_byte_0;
  logic [7:0] load_byte_1;
  logic       boundary;
  logic       preamble_active;

  assign boundary = (bit_cnt_q == LAST_BIT);

`ifdef PHY_TX_PREAMBLE_EN
  localparam int unsigned PRE_W = $clog2(PREAMBLE_FRAMES + 2);
  localparam logic [PRE_W-1:0] PRE_DONE = PRE_W'(PREAMBLE_FRAMES);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  assign preamble_active = (pre_cnt_q != PRE_DONE);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (boundary && preamble_active) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end
`else
  logic unused_preamble;
  assign unused_preamble = (PREAMBLE_FRAMES != 0);
  assign preamble_active = 1'b0;
`endif

  assign frame_sync = boundary && !preamble_active;

  // Source 0 is placed before source 1; each valid byte advances the lane pointer.
  always_comb begin
    lane_ptr_d  = lane_ptr_q;
    load_byte_0 = COM_BYTE;
    load_byte_1 = COM_BYTE;
    if (!preamble_active) begin
      if (smp_valid_q[0]) begin
        if (lane_ptr_d == LANE_0) begin
          load_byte_0 = smp_data_0_q;
        end else begin
          load_byte_1 = smp_data_0_q;
        end
        lane_ptr_d = next_lane(lane_ptr_d);
      end
      if (smp_valid_q[1]) begin
        if (lane_ptr_d == LANE_0) begin
          load_byte_0 = smp_data_1_q;
        end else begin
          load_byte_1 = smp_data_1_q;
        end
        lane_ptr_d = next_lane(lane_ptr_d);
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q    <= 3'd0;
      lane_ptr_q   <= LANE_0;
      smp_data_0_q <= 8'h00;
      smp_data_1_q <= 8'h00;
      smp_valid_q  <= 2'b00;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (boundary) begin
        lane_ptr_q   <= lane_ptr_d;
        smp_data_0_q <= data_in_0;
        smp_data_1_q <= data_in_1;
        smp_valid_q  <= {valid_in_1, valid_in_0} & {2{enable && !preamble_active}};
      end
    end
  end

  phy_tx_serializer u_ser_0 (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .load      (boundary),
    .load_data (load_byte_0),
    .serial_o  (out_0)
  );

  phy_tx_serializer u_ser_1 (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .load      (boundary),
    .load_data (load_byte_1),
    .serial_o  (out_1)
  );

endmodule

`default_nettype wire

// File: tb/tb_phy_tx.sv
// tb_phy_tx: randomized self-checking bench for phy_tx against a frame-level striping model.
// Revision 1.0
`default_nettype none

module tb_phy_tx;

  localparam logic [7:0] COM = 8'hBC;
  localparam int MAXF = 128;

  logic       clk_8f;
  logic       reset_L;
  logic       enable;
  logic [7:0] data_in_0;
  logic [7:0] data_in_1;
  logic       valid_in_0;
  logic       valid_in_1;
  logic       frame_sync;
  logic       out_0;
  logic       out_1;

  int n_vec;
  int n_err;

  // Model state: frame number since reset release, valid bytes striped so far,
  // and the byte each lane is expected to carry in every frame.
  int         frame_no;
  int         vcount;
  logic [7:0] exp0 [MAXF];
  logic [7:0] exp1 [MAXF];

  phy_tx #(
    .COM_BYTE        (COM),
    .PREAMBLE_FRAMES (4)
  ) dut (
    .clk_8f     (clk_8f),
    .reset_L    (reset_L),
    .enable     (enable),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .valid_in_0 (valid_in_0),
    .valid_in_1 (valid_in_1),
    .frame_sync (frame_sync),
    .out_0      (out_0),
    .out_1      (out_1)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  // Releases reset between a rising and a falling edge, so the next falling
  // edge is bit 0 of frame 1 and the next rising edge is edge 1.
  task automatic do_reset();
    reset_L    = 1'b0;
    enable     = 1'b1;
    data_in_0  = 8'h00;
    data_in_1  = 8'h00;
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    repeat (3) @(posedge clk_8f);
    #2;
    n_vec++;
    if ({out_0, out_1, frame_sync} !== 3'b000) begin
      n_err++;
      $display("FAIL in_reset: got %b expected 000", {out_0, out_1, frame_sync});
    end
    reset_L  = 1'b1;
    frame_no = 1;
    vcount   = 0;
    for (int i = 0; i < MAXF; i++) begin
      exp0[i] = COM;
      exp1[i] = COM;
    end
    exp0[1] = 8'h00;
    exp1[1] = 8'h00;
  endtask

  task automatic run_frame(input logic [7:0] d0, input logic v0,
                           input logic [7:0] d1, input logic v1, input logic en);
    logic [7:0] lane_byte [2];
    data_in_0  = d0;
    valid_in_0 = v0;
    data_in_1  = d1;
    valid_in_1 = v1;
    enable     = en;
    lane_byte[0] = COM;
    lane_byte[1] = COM;
    if (v0 && en) begin
      lane_byte[vcount % 2] = d0;
      vcount++;
    end
    if (v1 && en) begin
      lane_byte[vcount % 2] = d1;
      vcount++;
    end
    if (frame_no + 2 < MAXF) begin
      exp0[frame_no + 2] = lane_byte[0];
      exp1[frame_no + 2] = lane_byte[1];
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_8f);
      n_vec++;
      if (out_0 !== exp0[frame_no][7-j]) begin
        n_err++;
        $display("FAIL out_0 frame %0d bit %0d: got %b expected %b", frame_no, j, out_0, exp0[frame_no][7-j]);
      end
      n_vec++;
      if (out_1 !== exp1[frame_no][7-j]) begin
        n_err++;
        $display("FAIL out_1 frame %0d bit %0d: got %b expected %b", frame_no, j, out_1, exp1[frame_no][7-j]);
      end
      n_vec++;
      if (frame_sync !== (j == 7)) begin
        n_err++;
        $display("FAIL frame_sync frame %0d bit %0d: got %b expected %b", frame_no, j, frame_sync, (j == 7));
      end
    end
    @(posedge clk_8f);
    #1;
    frame_no++;
  endtask

  task automatic test_reset();
    logic [7:0] seen0, seen1;
    do_reset();
    for (int f = 0; f < 4; f++) run_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    // Frame 5 captured directly as whole bytes: both lanes must repeat BC.
    seen0 = 8'h00;
    seen1 = 8'h00;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk_8f);
      seen0 = {seen0[6:0], out_0};
      seen1 = {seen1[6:0], out_1};
    end
    @(posedge clk_8f);
    #1;
    frame_no++;
    n_vec++;
    if (seen0 !== 8'hBC || seen1 !== 8'hBC) begin
      n_err++;
      $display("FAIL idle_com: got %h/%h expected bc/bc", seen0, seen1);
    end
  endtask

  task automatic test_both_valid();
    do_reset();
    for (int f = 0; f < 5; f++) run_frame(8'hA5, 1'b1, 8'h3C, 1'b1, 1'b1);
  endtask

  task automatic test_single_valid();
    do_reset();
    run_frame(8'h11, 1'b1, 8'h77, 1'b0, 1'b1);
    run_frame(8'h22, 1'b1, 8'h77, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_enable_off();
    do_reset();
    for (int f = 0; f < 4; f++) run_frame(8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0);
  endtask

  task automatic test_enable_drop();
    do_reset();
    run_frame(8'h5A, 1'b1, 8'h96, 1'b1, 1'b1);
    run_frame(8'hC3, 1'b0, 8'h81, 1'b1, 1'b1);
    for (int f = 0; f < 4; f++) run_frame(8'hE7, 1'b1, 8'h18, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 40; f++) begin
      run_frame(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 7) != 0));
    end
    run_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    run_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_frame(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
    run_frame(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    // Frame 3 carries FF on both lanes; stop it three edges in.
    repeat (3) @(posedge clk_8f);
    #2;
    n_vec++;
    if ({out_0, out_1} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_byte_before_reset: got %b expected 11", {out_0, out_1});
    end
    reset_L = 1'b0;
    #1;
    n_vec++;
    if ({out_0, out_1, frame_sync} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: got %b expected 000", {out_0, out_1, frame_sync});
    end
    do_reset();
    for (int f = 0; f < 4; f++) run_frame(8'h96, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_both_valid();
    test_single_valid();
    test_enable_off();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
